// File: rtl/tdm_demux.sv
// TDM demultiplexer: locks onto frame_sync and steers slot words to per-channel registers.
// Define TDM_DEMUX_FRAME_BUF_EN to publish whole frames at once from a shadow buffer.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int CNT_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                     state_r, state_s;
  logic [CNT_W-1:0]           cnt_r, cnt_s;
  logic                       cap_s;
  logic [CNT_W-1:0]           slot_s;
  logic                       err_s;
  logic                       last_s;
  logic [NUM_CH*DATA_W-1:0]   data_r;
  logic [NUM_CH-1:0]          valid_r;
  logic                       frame_done_r;
  logic                       sync_err_r;
  logic                       locked_r;

  // Framing FSM: decides whether this beat is captured, into which slot, and any error.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cap_s   = 1'b0;
    slot_s  = ZERO_CNT;
    err_s   = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (din_valid && frame_sync) begin
          cap_s   = 1'b1;
          slot_s  = ZERO_CNT;
          state_s = LOCKED;
          cnt_s   = ONE_CNT;
        end else begin
          state_s = HUNT;
        end
      end
      LOCKED: begin
        if (!din_valid) begin
          state_s = LOCKED;
        end else if (frame_sync && (cnt_r != ZERO_CNT)) begin
          // Early sync: restart the frame on this beat rather than dropping lock.
          err_s  = 1'b1;
          cap_s  = 1'b1;
          slot_s = ZERO_CNT;
          cnt_s  = ONE_CNT;
        end else if (!frame_sync && (cnt_r == ZERO_CNT)) begin
          err_s   = 1'b1;
          state_s = HUNT;
          cnt_s   = ZERO_CNT;
        end else begin
          cap_s  = 1'b1;
          slot_s = cnt_r;
          last_s = (cnt_r == LAST_SLOT);
          if (cnt_r == LAST_SLOT) begin
            cnt_s = ZERO_CNT;
          end else begin
            cnt_s = cnt_r + ONE_CNT;
          end
        end
      end
      default: begin
        state_s = HUNT;
        cnt_s   = ZERO_CNT;
      end
    endcase
  end

  // FSM state and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
      cnt_r   <= ZERO_CNT;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Status pulses and lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      frame_done_r <= cap_s && last_s;
      sync_err_r   <= err_s;
      locked_r     <= (state_s == LOCKED);
    end
  end

`ifdef TDM_DEMUX_FRAME_BUF_EN
  logic [NUM_CH*DATA_W-1:0] shadow_r;
  logic [NUM_CH*DATA_W-1:0] frame_s;

  // Completed frame: buffered slots plus the final word arriving this beat.
  always_comb begin
    frame_s = shadow_r;
    frame_s[int'(LAST_SLOT)*DATA_W +: DATA_W] = din;
  end

  // Shadow buffer accumulates the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= {(NUM_CH*DATA_W){1'b0}};
    end else if (cap_s) begin
      shadow_r[int'(slot_s)*DATA_W +: DATA_W] <= din;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Publish all channels together only when a frame completes cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {(NUM_CH*DATA_W){1'b0}};
      valid_r <= {NUM_CH{1'b0}};
    end else if (cap_s && last_s) begin
      data_r  <= frame_s;
      valid_r <= {NUM_CH{1'b1}};
    end else begin
      valid_r <= {NUM_CH{1'b0}};
    end
  end
`else
  // Per-slot update: only the captured channel changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {(NUM_CH*DATA_W){1'b0}};
      valid_r <= {NUM_CH{1'b0}};
    end else if (cap_s) begin
      data_r[int'(slot_s)*DATA_W +: DATA_W] <= din;
      valid_r <= {{(NUM_CH-1){1'b0}}, 1'b1} << slot_s;
    end else begin
      valid_r <= {NUM_CH{1'b0}};
    end
  end
`endif

  assign ch_data    = data_r;
  assign ch_valid   = valid_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed framing scenarios then random beats vs a slot-level model.
module tb_tdm_demux;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;

  tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done), .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                       cyc;
    logic [NUM_CH-1:0]        vld;
    logic                     fd;
    logic                     se;
    logic [NUM_CH*DATA_W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference model state: lock flag, next expected slot, published and pending words.
  bit              m_locked;
  int              m_slot;
  logic [DATA_W-1:0] m_data[NUM_CH];
  logic [DATA_W-1:0] m_shadow[NUM_CH];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] pack();
    logic [NUM_CH*DATA_W-1:0] p;
    for (int k = 0; k < NUM_CH; k++) p[k*DATA_W +: DATA_W] = m_data[k];
    return p;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_slot   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_data[k]   = '0;
      m_shadow[k] = '0;
    end
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the next edge.
  task automatic step(input bit v, input bit s, input logic [DATA_W-1:0] d);
    exp_t e;
    int   k;
    bit   cap;
    @(posedge clk); #1;
    chk("locked", locked, m_locked);
    chk("ch_data_hold", ch_data, pack());
    din_valid = v; frame_sync = s; din = d;
    e.cyc = cyc + 1; e.vld = '0; e.fd = 1'b0; e.se = 1'b0;
    cap = 1'b0; k = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin cap = 1'b1; k = 0; m_locked = 1'b1; m_slot = 1; end
      end else if (s && m_slot != 0) begin
        e.se = 1'b1; cap = 1'b1; k = 0; m_slot = 1;
      end else if (!s && m_slot == 0) begin
        e.se = 1'b1; m_locked = 1'b0;
      end else begin
        cap = 1'b1; k = m_slot;
        e.fd = (m_slot == NUM_CH - 1);
        m_slot = (m_slot + 1) % NUM_CH;
      end
    end
    if (cap) begin
`ifdef TDM_DEMUX_FRAME_BUF_EN
      m_shadow[k] = d;
      if (e.fd) begin
        for (int j = 0; j < NUM_CH; j++) m_data[j] = m_shadow[j];
        e.vld = '1;
      end
`else
      m_data[k] = d;
      e.vld[k] = 1'b1;
`endif
    end
    e.data = pack();
    if (e.vld != '0 || e.fd || e.se) sbq.push_back(e);
  endtask

  // Monitor: every output event must match the oldest prediction, in the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (ch_valid != '0 || frame_done || sync_err)) begin
      if (sbq.size() == 0) begin
        chk("spurious_event", {ch_valid, frame_done, sync_err}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("ch_valid", ch_valid, e.vld);
        chk("frame_done", frame_done, e.fd);
        chk("sync_err", sync_err, e.se);
        chk("ch_data", ch_data, e.data);
      end
    end
  end

  task automatic clean_frame();
    step(1, 1, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_flags", {frame_done, locked, sync_err}, 0);
    #1 rst_n = 1'b1;

    // Clean frames, back to back.
    clean_frame(); clean_frame();
    step(0, 0, 8'h00);
    chk("clean_data", ch_data, 32'h44332211);
    chk("clean_locked", locked, 1'b1);

    // Gap between slot 1 and slot 2.
    step(1, 1, 8'h01); step(1, 0, 8'h02);
    step(0, 0, 8'hFF); step(0, 1, 8'hFF); step(0, 0, 8'hFF);
    step(1, 0, 8'h03); step(1, 0, 8'h04);

    // Early sync at counter 2, then continue the restarted frame.
    step(1, 1, 8'h11); step(1, 0, 8'h22);
    step(1, 1, 8'hAA); step(1, 0, 8'h77); step(1, 0, 8'h88); step(1, 0, 8'h99);
    step(0, 0, 8'h00);

    // Missing sync at counter 0, then beats ignored until a new sync.
    step(1, 0, 8'h5A); step(1, 0, 8'h5B); step(1, 0, 8'h5C);
    clean_frame();

    // Reset mid-frame after slot 1.
    step(1, 1, 8'hC0); step(1, 0, 8'hC1); step(0, 0, 8'h00);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_ch_data", ch_data, 0);
    chk("midrst_ch_valid", ch_valid, 0);
    chk("midrst_flags", {frame_done, locked, sync_err}, 0);
    model_reset();
    sbq.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    step(1, 0, 8'h55); step(1, 1, 8'h66); step(1, 0, 8'h67);
    step(1, 0, 8'h68); step(1, 0, 8'h69);

    // Random traffic, mostly well-framed with occasional violations.
    for (int i = 0; i < 400; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_locked && m_slot == 0) s = ($urandom_range(0, 7) != 0);
      else s = ($urandom_range(0, 9) == 0);
      step(v, s, DATA_W'($urandom));
    end
    step(0, 0, 8'h00); step(0, 0, 8'h00);
    @(negedge clk); #1;
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of time slots per frame; legal values are 2 to 16.
REQ-002 The block SHALL have parameter DATA_W, default 8, width of one slot word.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port din SHALL be an input, DATA_W bits: the time-multiplexed slot word.
REQ-006 Port din_valid SHALL be an input, 1 bit: din carries a slot word this cycle (a "beat").
REQ-007 Port frame_sync SHALL be an input, 1 bit: the current beat is slot 0; it is ignored when din_valid is 0.
REQ-008 Port ch_data SHALL be an output, NUM_CH*DATA_W bits: registered per-channel words, channel k at bits [k*DATA_W +: DATA_W].
REQ-009 Port ch_valid SHALL be an output, NUM_CH bits: one-cycle pulse per channel whose ch_data field was updated.
REQ-010 Port frame_done SHALL be an output, 1 bit: one-cycle pulse when slot NUM_CH-1 is captured.
REQ-011 Port locked SHALL be an output, 1 bit: high while the FSM is in LOCKED.
REQ-012 Port sync_err SHALL be an output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-013 The FSM SHALL have exactly two states, HUNT and LOCKED, plus a slot counter of width clog2(NUM_CH).
REQ-014 In HUNT, a beat with frame_sync=0 SHALL be discarded with no output change.
REQ-015 In HUNT, a beat with frame_sync=1 SHALL be captured as slot 0, move the FSM to LOCKED, and set the slot counter to 1.
REQ-016 In LOCKED, each beat SHALL be captured into the channel equal to the slot counter, and the counter SHALL then increment.
REQ-017 The counter SHALL wrap from NUM_CH-1 to 0.
REQ-018 Cycles with din_valid=0 SHALL leave the counter, the FSM state and all data unchanged.
REQ-019 Capture latency SHALL be one cycle: a beat at edge N appears on ch_data, with its ch_valid bit high, after edge N+1.
REQ-020 frame_done SHALL pulse in the same cycle as the ch_valid for slot NUM_CH-1.
REQ-021 In LOCKED, a beat with frame_sync=1 while the counter is not 0 SHALL do all of the following: pulse sync_err, capture the beat as slot 0, set the counter to 1, and remain LOCKED (resync).
REQ-022 In LOCKED, a beat with frame_sync=0 while the counter is 0 SHALL do all of the following: pulse sync_err, discard the beat, and return to HUNT.
REQ-023 In LOCKED, a beat with frame_sync=1 while the counter is 0 SHALL be normal operation, with no error.
REQ-024 Where REQ-021 and REQ-020 coincide, the sync_err event SHALL take priority: no frame_done is issued for the truncated frame.
REQ-025 ch_data fields that are not updated SHALL hold their previous values.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in HUNT and the counter SHALL be 0.
REQ-027 While rst_n=0, ch_data, ch_valid, frame_done, locked and sync_err SHALL all be 0.
REQ-028 Assertion of rst_n mid-frame SHALL take effect immediately without waiting for a clock edge, and any partial frame SHALL be lost.
REQ-029 After release of rst_n, the first capture SHALL require a beat with frame_sync=1.

Configuration
REQ-030 Macro TDM_DEMUX_FRAME_BUF_EN SHALL select the output buffering mode.
REQ-031 With the macro defined, slots SHALL accumulate in a shadow buffer.
REQ-032 With the macro defined, ch_data SHALL update for all channels at once, with all ch_valid bits high for one cycle, coincident with frame_done.
REQ-033 With the macro defined, a frame aborted by REQ-021 or REQ-022 SHALL never reach ch_data.
REQ-034 With the macro undefined, channels SHALL update per slot as in REQ-019, and no shadow buffer SHALL be instantiated.

Verification
REQ-035 Bench SHALL cover clean frames: NUM_CH=4; beats 0x11(sync), 0x22, 0x33, 0x44, twice, back-to-back -> ch_valid 0001, 0010, 0100, 1000 in successive cycles; frame_done with the last; ch_data=0x44332211; locked=1.
REQ-036 Bench SHALL cover gaps: din_valid low for 3 cycles between slot 1 and slot 2 -> no ch_valid during the gap; slot 2 lands in channel 2; no sync_err.
REQ-037 Bench SHALL cover early sync: frame_sync=1 on the beat at counter 2 with data 0xAA -> sync_err for one cycle; ch_data[7:0]=0xAA; next beat goes to channel 1; locked stays 1.
REQ-038 Bench SHALL cover missing sync: in LOCKED, the beat at counter 0 has frame_sync=0 -> sync_err pulse; locked=0; the beat is discarded; beats stay ignored until the next frame_sync.
REQ-039 Bench SHALL cover reset mid-frame: rst_n=0 after slot 1 -> all outputs 0 immediately; after release, 0x55 without sync is ignored, and the first synced beat goes to channel 0.
REQ-040 Bench SHALL cover buffered mode: with TDM_DEMUX_FRAME_BUF_EN, run the REQ-035 sequence -> ch_valid=1111 once per frame with frame_done; a frame aborted per REQ-037 leaves ch_data unchanged.
